psg_frame_sequencer: RTL and testbench

PSG_FRAME_SEQUENCER -- requirements
Module: psg_frame_sequencer

---
 rtl/psg_frame_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_psg_frame_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/psg_frame_sequencer.sv
// Replays dirty shadow registers to an AY PSG each frame, 2*(HOLD+1) clk28 per register; cpu_req stalls only between registers.
// Defining PSG_SEQ_TS_EN adds a second shadow bank (chip 1) with FE/FF chip-select transactions.
module psg_frame_sequencer #(
  parameter int HOLD  = 8,
  parameter int NREGS = 14
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       frame_int,
  input  logic       cpu_req,
  output logic       cpu_gnt,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
`ifdef PSG_SEQ_TS_EN
  input  logic       wr_chip,
  output logic       chip_sel,
`endif
  output logic       ay_bdir,
  output logic       ay_bc1,
  output logic [7:0] ay_di,
  output logic       busy,
  output logic       done
);

`ifdef PSG_SEQ_TS_EN
  localparam int NB = 2;
  logic wr_bank;
  logic chip_q;
  assign wr_bank  = wr_chip;
  assign chip_sel = chip_q;
`else
  localparam int NB = 1;
  logic wr_bank;
  assign wr_bank = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_LATCH, S_LGAP, S_WRITE, S_WGAP, S_DONE} state_t;

  state_t           state_q;
  logic [7:0]       shadow_q [NB][NREGS];
  logic [NREGS-1:0] dirty_q  [NB];
  logic [NREGS-1:0] dirty_d  [NB];
  logic [NREGS-1:0] work_q   [NB];
  logic             pend_q;
  logic [3:0]       idx_q;
  logic             bank_q;
  logic             sel_q;
  logic [7:0]       data_q;
  logic [7:0]       cnt_q;
  logic             bdir_q, bc1_q, busy_q, done_q, gnt_q;
  logic [7:0]       di_q;

  logic             snap, wr_hit;
  logic [NREGS-1:0] wr_oh;
  logic [NB-1:0]    pick_vld;
  logic [3:0]       pick_idx [NB];
  logic             arb_any_d, arb_sel_d, arb_bank_d;
  logic [3:0]       arb_idx_d;
  logic [7:0]       arb_di_d;

  assign snap   = (state_q == S_IDLE) && (frame_int || pend_q);
  assign wr_hit = wr_en && (int'(wr_addr) < NREGS);
  assign wr_oh  = {{(NREGS-1){1'b0}}, 1'b1} << wr_addr;

  // A write landing on the snapshot cycle survives the clear and belongs to the next frame.
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      dirty_d[b] = snap ? '0 : dirty_q[b];
      if (wr_hit && (int'(wr_bank) == b))
        dirty_d[b] = dirty_d[b] | wr_oh;
    end
  end

  always_comb begin
    for (int b = 0; b < NB; b++) begin
      pick_vld[b] = 1'b0;
      pick_idx[b] = '0;
      for (int i = NREGS-1; i >= 0; i--) begin
        if (work_q[b][i]) begin
          pick_vld[b] = 1'b1;
          pick_idx[b] = 4'(i);
        end
      end
    end
  end

  always_comb begin
    arb_any_d  = |pick_vld;
    arb_sel_d  = 1'b0;
    arb_bank_d = 1'b0;
    arb_idx_d  = pick_idx[0];
    arb_di_d   = {4'b0, pick_idx[0]};
`ifdef PSG_SEQ_TS_EN
    // Chip 0 first; a select transaction precedes any switch of the addressed chip.
    if (pick_vld[0] && chip_q) begin
      arb_sel_d = 1'b1;
      arb_di_d  = 8'hFF;
    end else if (!pick_vld[0] && pick_vld[1]) begin
      if (!chip_q) begin
        arb_sel_d = 1'b1;
        arb_di_d  = 8'hFE;
      end else begin
        arb_bank_d = 1'b1;
        arb_idx_d  = pick_idx[1];
        arb_di_d   = {4'b0, pick_idx[1]};
      end
    end
`endif
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      for (int b = 0; b < NB; b++) begin
        dirty_q[b] <= '0;
        for (int r = 0; r < NREGS; r++) shadow_q[b][r] <= '0;
      end
    end else begin
      if (wr_hit) shadow_q[wr_bank][wr_addr] <= wr_data;
      for (int b = 0; b < NB; b++) dirty_q[b] <= dirty_d[b];
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      idx_q   <= '0;
      bank_q  <= 1'b0;
      sel_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      bdir_q  <= 1'b0;
      bc1_q   <= 1'b0;
      di_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gnt_q   <= 1'b1;
      for (int b = 0; b < NB; b++) work_q[b] <= '0;
`ifdef PSG_SEQ_TS_EN
      chip_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (frame_int && (state_q != S_IDLE)) pend_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (snap) begin
            state_q <= S_ARB;
            busy_q  <= 1'b1;
            pend_q  <= 1'b0;
            for (int b = 0; b < NB; b++) work_q[b] <= dirty_q[b];
          end
        end
        S_ARB: begin
          if (!arb_any_d) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (!cpu_req) begin
            state_q <= S_LATCH;
            gnt_q   <= 1'b0;
            bdir_q  <= 1'b1;
            bc1_q   <= 1'b1;
            di_q    <= arb_di_d;
            cnt_q   <= 8'(HOLD-1);
            idx_q   <= arb_idx_d;
            bank_q  <= arb_bank_d;
            sel_q   <= arb_sel_d;
            data_q  <= shadow_q[arb_bank_d][arb_idx_d];
          end
        end
        S_LATCH: begin
          if (cnt_q == 8'd0) begin
            state_q <= S_LGAP;
            bdir_q  <= 1'b0;
            bc1_q   <= 1'b0;
            di_q    <= '0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_LGAP: begin
          if (sel_q) begin
            state_q <= S_WGAP;
          end else begin
            state_q <= S_WRITE;
            bdir_q  <= 1'b1;
            di_q    <= data_q;
            cnt_q   <= 8'(HOLD-1);
          end
        end
        S_WRITE: begin
          if (cnt_q == 8'd0) begin
            state_q <= S_WGAP;
            bdir_q  <= 1'b0;
            di_q    <= '0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_WGAP: begin
          if (!sel_q) work_q[bank_q][idx_q] <= 1'b0;
`ifdef PSG_SEQ_TS_EN
          if (sel_q) chip_q <= ~chip_q;
`endif
          state_q <= S_ARB;
          gnt_q   <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ay_bdir = bdir_q;
  assign ay_bc1  = bc1_q;
  assign ay_di   = di_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cpu_gnt = gnt_q;

endmodule

// File: tb/tb_psg_frame_sequencer.sv
// Bench for psg_frame_sequencer: table of single-cycle vectors plus directed multi-cycle frame sequences.
module tb_psg_frame_sequencer;
  logic       clk28 = 1'b0;
  logic       rst = 1'b0, frame_int = 1'b0, cpu_req = 1'b0, wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       cpu_gnt, ay_bdir, ay_bc1, busy, done;
  logic [7:0] ay_di;

  int chk_cnt = 0, pass_cnt = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, bus_cyc = 0, viol = 0;
  int k, t0;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] di;
    int         len;
  } txn_t;
  txn_t       log_q[$];
  logic [1:0] cur_kind = 2'd0;
  logic [7:0] cur_di = '0;
  int         cur_len = 0;

  typedef struct {
    logic       r, f, we, cr;
    logic [3:0] a;
    logic [7:0] d;
    logic [2:0] exp;
  } vec_t;
  vec_t vecs[20];

  always #5 clk28 = ~clk28;

  psg_frame_sequencer #(.HOLD(8), .NREGS(14)) dut (
    .clk28(clk28), .rst(rst), .frame_int(frame_int), .cpu_req(cpu_req), .cpu_gnt(cpu_gnt),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ay_bdir(ay_bdir), .ay_bc1(ay_bc1), .ay_di(ay_di), .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Advance one cycle, sample just after the edge and fold the bus into LATCH(1)/WRITE(2) runs.
  task automatic step();
    logic [1:0] kd;
    txn_t       e;
    @(posedge clk28);
    #1;
    cyc++;
    kd = ay_bdir ? (ay_bc1 ? 2'd1 : 2'd2) : 2'd0;
    if (kd != 2'd0 && kd == cur_kind && ay_di == cur_di) begin
      cur_len++;
    end else begin
      if (cur_kind != 2'd0) begin
        e.kind = cur_kind; e.di = cur_di; e.len = cur_len;
        log_q.push_back(e);
      end
      cur_kind = kd;
      cur_di   = ay_di;
      cur_len  = (kd != 2'd0) ? 1 : 0;
    end
    if (cpu_gnt && (ay_bdir || ay_bc1 || ay_di != 8'd0)) viol++;
    if (!cpu_gnt) bus_cyc++;
    if (done) begin done_cnt++; done_cyc = cyc; end
  endtask

  task automatic clr_log();
    log_q.delete();
    cur_kind = 2'd0; cur_len = 0;
    done_cnt = 0; bus_cyc = 0; viol = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; frame_int = 1'b0; wr_en = 1'b0; cpu_req = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n0 = done_cnt;
    int n  = 0;
    while (done_cnt == n0 && n < budget) begin step(); n++; end
    chk(name, 32'(done_cnt != n0), 32'd1);
  endtask

  function automatic logic [31:0] tx(input logic [1:0] kd, input logic [7:0] d, input int n);
    return {14'b0, kd, d, 8'(n)};
  endfunction

  function automatic logic [31:0] get(input int i);
    if (i < log_q.size()) return {14'b0, log_q[i].kind, log_q[i].di, 8'(log_q[i].len)};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic vec_t v(input logic r, input logic f, input logic we, input logic [3:0] a,
                             input logic [7:0] d, input logic cr, input logic [2:0] e);
    vec_t x;
    x.r = r; x.f = f; x.we = we; x.a = a; x.d = d; x.cr = cr; x.exp = e;
    return x;
  endfunction

  initial begin
    // expected outputs are {busy, done, cpu_gnt}; bus must stay idle throughout
    vecs[0]  = v(1, 0, 0, 4'd0,  8'h00, 0, 3'b001);
    vecs[1]  = v(0, 0, 0, 4'd0,  8'h00, 0, 3'b001);
    vecs[2]  = v(0, 1, 0, 4'd0,  8'h00, 0, 3'b101);
    vecs[3]  = v(0, 0, 0, 4'd0,  8'h00, 0, 3'b111);
    vecs[4]  = v(0, 0, 0, 4'd0,  8'h00, 0, 3'b001);
    vecs[5]  = v(0, 0, 1, 4'd14, 8'hAA, 0, 3'b001);
    vecs[6]  = v(0, 0, 1, 4'd15, 8'hBB, 0, 3'b001);
    vecs[7]  = v(0, 1, 0, 4'd0,  8'h00, 0, 3'b101);
    vecs[8]  = v(0, 0, 0, 4'd0,  8'h00, 0, 3'b111);
    vecs[9]  = v(0, 0, 0, 4'd0,  8'h00, 0, 3'b001);
    vecs[10] = v(0, 1, 0, 4'd0,  8'h00, 1, 3'b101);
    vecs[11] = v(0, 0, 0, 4'd0,  8'h00, 1, 3'b111);
    vecs[12] = v(0, 0, 0, 4'd0,  8'h00, 0, 3'b001);
    vecs[13] = v(0, 1, 0, 4'd0,  8'h00, 0, 3'b101);
    vecs[14] = v(0, 1, 0, 4'd0,  8'h00, 0, 3'b111);
    vecs[15] = v(0, 0, 0, 4'd0,  8'h00, 0, 3'b001);
    vecs[16] = v(0, 0, 0, 4'd0,  8'h00, 0, 3'b101);
    vecs[17] = v(0, 0, 0, 4'd0,  8'h00, 0, 3'b111);
    vecs[18] = v(0, 0, 0, 4'd0,  8'h00, 0, 3'b001);
    vecs[19] = v(0, 0, 0, 4'd0,  8'h00, 0, 3'b001);

    for (int i = 0; i < 20; i++) begin
      rst = vecs[i].r; frame_int = vecs[i].f; wr_en = vecs[i].we;
      wr_addr = vecs[i].a; wr_data = vecs[i].d; cpu_req = vecs[i].cr;
      step();
      chk($sformatf("vec%0d", i), {19'b0, busy, done, cpu_gnt, ay_bdir, ay_bc1, ay_di},
          {19'b0, vecs[i].exp, 10'b0});
    end
    frame_int = 1'b0; wr_en = 1'b0; cpu_req = 1'b0;

    // two dirty registers, serviced lowest index first
    do_reset();
    wr(4'd7, 8'h38); wr(4'd0, 8'h55);
    clr_log();
    frame_int = 1'b1; step(); frame_int = 1'b0;
    t0 = cyc;
    chk("A_arb", {30'b0, busy, cpu_gnt}, 32'b11);
    wait_done("A_done", 200);
    chk("A_done_latency", done_cyc - t0, 39);
    chk("A_bus_cycles", bus_cyc, 36);
    chk("A_ntx", log_q.size(), 4);
    chk("A_tx0", get(0), tx(2'd1, 8'h00, 8));
    chk("A_tx1", get(1), tx(2'd2, 8'h55, 8));
    chk("A_tx2", get(2), tx(2'd1, 8'h07, 8));
    chk("A_tx3", get(3), tx(2'd2, 8'h38, 8));
    chk("A_idle_when_gnt", viol, 0);

    // CPU holds off the sequencer in ARB, then cannot preempt a WRITE
    do_reset();
    wr(4'd1, 8'hA1);
    clr_log();
    cpu_req = 1'b1; frame_int = 1'b1; step(); frame_int = 1'b0;
    for (int i = 0; i < 19; i++) step();
    chk("B_stall_bus", bus_cyc, 0);
    chk("B_stall_state", {30'b0, busy, cpu_gnt}, 32'b11);
    cpu_req = 1'b0; step();
    chk("B_latch_next", {21'b0, ay_bdir, ay_bc1, ay_di, cpu_gnt}, {21'b0, 1'b1, 1'b1, 8'h01, 1'b0});
    k = 0;
    while (!(ay_bdir && !ay_bc1) && k < 40) begin step(); k++; end
    cpu_req = 1'b1;
    wait_done("B_done", 100);
    cpu_req = 1'b0;
    chk("B_ntx", log_q.size(), 2);
    chk("B_tx0", get(0), tx(2'd1, 8'h01, 8));
    chk("B_tx1", get(1), tx(2'd2, 8'hA1, 8));

    // envelope shape written on the snapshot cycle goes out exactly once, one frame later
    do_reset();
    clr_log();
    frame_int = 1'b1; wr_en = 1'b1; wr_addr = 4'd13; wr_data = 8'h0E;
    step();
    frame_int = 1'b0; wr_en = 1'b0;
    wait_done("C1_done", 20);
    chk("C1_ntx", log_q.size(), 0);
    step(); step();
    clr_log();
    frame_int = 1'b1; step(); frame_int = 1'b0;
    wait_done("C2_done", 100);
    chk("C2_ntx", log_q.size(), 2);
    chk("C2_tx0", get(0), tx(2'd1, 8'h0D, 8));
    chk("C2_tx1", get(1), tx(2'd2, 8'h0E, 8));
    step(); step();
    clr_log();
    frame_int = 1'b1; step(); frame_int = 1'b0;
    wait_done("C3_done", 20);
    chk("C3_bus_cycles", bus_cyc, 0);

    // two frame strobes while busy collapse into one extra sequence
    do_reset();
    wr(4'd2, 8'h22);
    clr_log();
    frame_int = 1'b1; step(); frame_int = 1'b0; step();
    frame_int = 1'b1; step(); frame_int = 1'b0;
    wr(4'd3, 8'h33);
    frame_int = 1'b1; step(); frame_int = 1'b0;
    for (int i = 0; i < 150; i++) step();
    chk("D_done_cnt", done_cnt, 2);
    chk("D_ntx", log_q.size(), 4);
    chk("D_tx0", get(0), tx(2'd1, 8'h02, 8));
    chk("D_tx1", get(1), tx(2'd2, 8'h22, 8));
    chk("D_tx2", get(2), tx(2'd1, 8'h03, 8));
    chk("D_tx3", get(3), tx(2'd2, 8'h33, 8));

    // reset in the middle of a WRITE phase
    do_reset();
    wr(4'd5, 8'h5A);
    frame_int = 1'b1; step(); frame_int = 1'b0;
    k = 0;
    while (!(ay_bdir && !ay_bc1) && k < 40) begin step(); k++; end
    step(); step();
    chk("E_in_write", {22'b0, ay_bdir, ay_bc1, ay_di}, {22'b0, 1'b1, 1'b0, 8'h5A});
    rst = 1'b1; step(); rst = 1'b0;
    chk("E_rst_abort", {28'b0, ay_bdir, busy, cpu_gnt, done}, 32'b0010);
    clr_log();
    for (int i = 0; i < 30; i++) step();
    chk("E_stays_idle", bus_cyc + done_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
